// File: rtl/race_controller.sv
// race_controller
// Game-flow controller for a two-player key-mashing race.
// Sequence: MENU -> COUNTDOWN (3,2,1) -> RACE -> FINISH, driven by frame ticks
// taken from the rising edge of vsync_in. Everything runs in the clk domain.
//
// Ports
//   clk          in   system (pixel) clock
//   rst          in   asynchronous active-high reset
//   vsync_in     in   VGA vsync; its rising edge is the frame tick
//   key_posedge  in   [0] P1 accelerate, [1] P2 accelerate, [2] unused, [3] abort
//   start_req    in   one-cycle race request from the menu logic
//   game_state   out  0 MENU, 1 COUNTDOWN, 2 RACE, 3 FINISH
//   countdown    out  countdown digit 3..0
//   go_pulse     out  one-cycle pulse on entry to RACE
//   xpos_p1/p2   out  car x-positions in pixels
//   winner       out  0 none, 1 P1, 2 P2, 3 tie
module race_controller #(
  parameter int FRAMES_PER_STEP = 60,
  parameter int START_X         = 256,
  parameter int FINISH_X        = 896,
  parameter int SPEED_MAX       = 15,
  parameter int DECAY_FRAMES    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync_in,
  input  logic [3:0]  key_posedge,
  input  logic        start_req,
  output logic [1:0]  game_state,
  output logic [1:0]  countdown,
  output logic        go_pulse,
  output logic [10:0] xpos_p1,
  output logic [10:0] xpos_p2,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    ST_MENU      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } state_t;

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int DCW = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAMES_PER_STEP - 1);
  localparam logic [DCW-1:0] DECAY_LAST = DCW'(DECAY_FRAMES - 1);
  localparam logic [10:0]    START_POS  = 11'(START_X);
  localparam logic [10:0]    FINISH_POS = 11'(FINISH_X);
  localparam logic [11:0]    FINISH_SUM = 12'(FINISH_X);
  localparam logic [3:0]     SPD_MAX    = 4'(SPEED_MAX);

  state_t         state, state_nx;
  logic [1:0]     countdown_nx;
  logic           go_nx;
  logic [10:0]    x1_nx, x2_nx;
  logic [1:0]     win_nx;
  logic [3:0]     spd1, spd2, spd1_nx, spd2_nx;
  logic [FCW-1:0] frame_cnt, frame_nx;
  logic [DCW-1:0] decay_cnt, decay_nx;
  logic           vsync_d;

  logic           tick;
  logic           acc1, acc2, abort;
  logic           decay;
  logic           cross1, cross2;
  logic [11:0]    sum1, sum2;
  logic           load_start, go_menu;
  logic           unused_key;

  assign tick       = vsync_in & ~vsync_d;
  assign acc1       = key_posedge[0];
  assign acc2       = key_posedge[1];
  assign abort      = key_posedge[3];
  assign unused_key = key_posedge[2];
  assign game_state = state;

  // A press and a decay in the same cycle cancel; otherwise press saturates
  // upward and decay stops at zero.
  function automatic logic [3:0] next_speed(input logic [3:0] spd,
                                            input logic       key,
                                            input logic       dec);
    logic [3:0] r;
    if (key && dec)
      r = spd;
    else if (key)
      r = (spd >= SPD_MAX) ? SPD_MAX : spd + 4'd1;
    else if (dec && (spd != 4'd0))
      r = spd - 4'd1;
    else
      r = spd;
    return r;
  endfunction

  // State and output registers; reset leaves vsync_d high so a vsync that is
  // already high at release is not mistaken for a new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_MENU;
      countdown <= 2'd3;
      go_pulse  <= 1'b0;
      xpos_p1   <= START_POS;
      xpos_p2   <= START_POS;
      winner    <= 2'd0;
      spd1      <= 4'd0;
      spd2      <= 4'd0;
      frame_cnt <= {FCW{1'b0}};
      decay_cnt <= {DCW{1'b0}};
      vsync_d   <= 1'b1;
    end else begin
      state     <= state_nx;
      countdown <= countdown_nx;
      go_pulse  <= go_nx;
      xpos_p1   <= x1_nx;
      xpos_p2   <= x2_nx;
      winner    <= win_nx;
      spd1      <= spd1_nx;
      spd2      <= spd2_nx;
      frame_cnt <= frame_nx;
      decay_cnt <= decay_nx;
      vsync_d   <= vsync_in;
    end
  end

  // Next-state and datapath update for all game phases.
  always_comb begin
    state_nx     = state;
    countdown_nx = countdown;
    go_nx        = 1'b0;
    x1_nx        = xpos_p1;
    x2_nx        = xpos_p2;
    win_nx       = winner;
    spd1_nx      = spd1;
    spd2_nx      = spd2;
    frame_nx     = frame_cnt;
    decay_nx     = decay_cnt;
    load_start   = 1'b0;
    go_menu      = 1'b0;
    decay        = 1'b0;
    cross1       = 1'b0;
    cross2       = 1'b0;
    // Positions advance by the speed held before this cycle's key/decay update.
    sum1         = {1'b0, xpos_p1} + {8'd0, spd1};
    sum2         = {1'b0, xpos_p2} + {8'd0, spd2};

    case (state)
      ST_MENU: begin
        if (start_req)
          load_start = 1'b1;
        else
          load_start = 1'b0;
      end

      ST_COUNTDOWN: begin
        if (abort) begin
          go_menu = 1'b1;
        end else if (acc1 && acc2) begin
          // Simultaneous false start by both: start the count over.
          countdown_nx = 2'd3;
          frame_nx     = {FCW{1'b0}};
          win_nx       = 2'd0;
        end else if (acc1) begin
          state_nx = ST_FINISH;
          win_nx   = 2'd2;
        end else if (acc2) begin
          state_nx = ST_FINISH;
          win_nx   = 2'd1;
        end else if (tick) begin
          if (frame_cnt == FRAME_LAST) begin
            frame_nx = {FCW{1'b0}};
            if (countdown == 2'd1) begin
              state_nx     = ST_RACE;
              countdown_nx = 2'd0;
              go_nx        = 1'b1;
            end else begin
              countdown_nx = countdown - 2'd1;
            end
          end else begin
            frame_nx = frame_cnt + FCW'(1);
          end
        end else begin
          frame_nx = frame_cnt;
        end
      end

      ST_RACE: begin
        if (abort) begin
          go_menu = 1'b1;
        end else begin
          decay   = tick && (decay_cnt == DECAY_LAST);
          spd1_nx = next_speed(spd1, acc1, decay);
          spd2_nx = next_speed(spd2, acc2, decay);
          if (tick) begin
            decay_nx = decay ? {DCW{1'b0}} : decay_cnt + DCW'(1);
            cross1   = (sum1 >= FINISH_SUM);
            cross2   = (sum2 >= FINISH_SUM);
            x1_nx    = cross1 ? FINISH_POS : sum1[10:0];
            x2_nx    = cross2 ? FINISH_POS : sum2[10:0];
            if (cross1 || cross2) begin
              state_nx = ST_FINISH;
              // {P2,P1} crossing flags map directly onto the winner code.
              win_nx   = {cross2, cross1};
            end else begin
              state_nx = ST_RACE;
            end
          end else begin
            decay_nx = decay_cnt;
          end
        end
      end

      ST_FINISH: begin
        if (abort)
          go_menu = 1'b1;
        else if (start_req)
          load_start = 1'b1;
        else
          state_nx = ST_FINISH;
      end

      default: begin
        go_menu = 1'b1;
      end
    endcase

    // Both menu return and race start reinitialise the race datapath.
    if (go_menu || load_start) begin
      state_nx     = go_menu ? ST_MENU : ST_COUNTDOWN;
      countdown_nx = 2'd3;
      go_nx        = 1'b0;
      x1_nx        = START_POS;
      x2_nx        = START_POS;
      win_nx       = 2'd0;
      spd1_nx      = 4'd0;
      spd2_nx      = 4'd0;
      frame_nx     = {FCW{1'b0}};
      decay_nx     = {DCW{1'b0}};
    end else begin
      // No reinitialisation this cycle; case results stand.
    end
  end

endmodule

// File: tb/tb_race_controller.sv
// Scoreboard bench for race_controller (FRAMES_PER_STEP=4, DECAY_FRAMES=8).
// Stimulus pushes expected output snapshots tagged with the cycle they become
// visible; a negedge monitor pops and compares them.
module tb_race_controller;

  localparam logic [1:0] S_MENU = 2'd0;
  localparam logic [1:0] S_CD   = 2'd1;
  localparam logic [1:0] S_RACE = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        vsync_in;
  logic [3:0]  key_posedge;
  logic        start_req;
  logic [1:0]  game_state;
  logic [1:0]  countdown;
  logic        go_pulse;
  logic [10:0] xpos_p1;
  logic [10:0] xpos_p2;
  logic [1:0]  winner;

  race_controller #(
    .FRAMES_PER_STEP(4),
    .START_X(256),
    .FINISH_X(896),
    .SPEED_MAX(15),
    .DECAY_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vsync_in(vsync_in),
    .key_posedge(key_posedge),
    .start_req(start_req),
    .game_state(game_state),
    .countdown(countdown),
    .go_pulse(go_pulse),
    .xpos_p1(xpos_p1),
    .xpos_p2(xpos_p2),
    .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [1:0]  st;
    logic [1:0]  cd;
    logic        go;
    logic [10:0] x1;
    logic [10:0] x2;
    logic [1:0]  win;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  logic [1:0]  e_st;
  logic [1:0]  e_cd;
  logic        e_go;
  logic [10:0] e_x1;
  logic [10:0] e_x2;
  logic [1:0]  e_win;

  // Cycle counter used to time-tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation that has become due.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.due != cyc || game_state !== e.st || countdown !== e.cd ||
          go_pulse !== e.go || xpos_p1 !== e.x1 || xpos_p2 !== e.x2 ||
          winner !== e.win) begin
        errors++;
        $display("FAIL %s: got st=%0d cd=%0d go=%0d x1=%0d x2=%0d win=%0d, want st=%0d cd=%0d go=%0d x1=%0d x2=%0d win=%0d",
                 e.name, game_state, countdown, go_pulse, xpos_p1, xpos_p2, winner,
                 e.st, e.cd, e.go, e.x1, e.x2, e.win);
      end
    end
  end

  task automatic set_exp(input logic [1:0] st, input logic [1:0] cd, input logic go,
                         input logic [10:0] x1, input logic [10:0] x2, input logic [1:0] win);
    e_st = st; e_cd = cd; e_go = go; e_x1 = x1; e_x2 = x2; e_win = win;
  endtask

  task automatic push_exp(input int due, input string nm);
    exp_t e;
    e.due = due; e.name = nm; e.st = e_st; e.cd = e_cd; e.go = e_go;
    e.x1 = e_x1; e.x2 = e_x2; e.win = e_win;
    q.push_back(e);
  endtask

  // One input cycle; with chk set, the current expectation applies after the
  // next rising edge.
  task automatic step(input logic v, input logic [3:0] k, input logic s,
                      input bit chk, input string nm);
    @(negedge clk);
    vsync_in = v; key_posedge = k; start_req = s;
    if (chk) push_exp(cyc + 1, nm);
  endtask

  // One frame tick (vsync high then low), keys applied with the tick.
  task automatic tick(input logic [3:0] k, input bit chk, input string nm);
    step(1'b1, k, 1'b0, chk, nm);
    step(1'b0, 4'd0, 1'b0, 1'b0, "");
  endtask

  // start_req plus the 12 countdown ticks needed to reach RACE.
  task automatic to_race();
    step(1'b0, 4'd0, 1'b1, 1'b0, "");
    for (int i = 0; i < 12; i++) tick(4'd0, 1'b0, "");
  endtask

  initial begin
    rst = 1'b1; vsync_in = 1'b0; key_posedge = 4'd0; start_req = 1'b0;

    // Reset values
    set_exp(S_MENU, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    @(posedge clk); #1; push_exp(cyc, "reset");
    @(negedge clk); rst = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b1, "menu_idle");
    tick(4'b0011, 1'b1, "menu_tick_keys");

    // Start sequence: digit drops after ticks 4 and 8, RACE at tick 12
    set_exp(S_CD, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    step(1'b0, 4'd0, 1'b1, 1'b1, "start");
    for (int t = 1; t <= 11; t++) begin
      set_exp(S_CD, 2'(3 - t / 4), 1'b0, 11'd256, 11'd256, 2'd0);
      tick(4'd0, 1'b1, "countdown");
    end
    set_exp(S_RACE, 2'd0, 1'b1, 11'd256, 11'd256, 2'd0);
    step(1'b1, 4'd0, 1'b0, 1'b1, "go");
    set_exp(S_RACE, 2'd0, 1'b0, 11'd256, 11'd256, 2'd0);
    step(1'b0, 4'd0, 1'b0, 1'b1, "go_clear");

    // Acceleration: 20 presses saturate P1 at 15; start_req ignored in RACE
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0001, 1'b0, 1'b0, "");
    step(1'b0, 4'd0, 1'b1, 1'b1, "start_ignored");
    set_exp(S_RACE, 2'd0, 1'b0, 11'd271, 11'd256, 2'd0);
    tick(4'd0, 1'b1, "accel");
    // Ticks 2..8 at 15, decay on tick 8, tick 9 at 14 -> 390
    begin
      int x;
      x = 271;
      for (int t = 2; t <= 9; t++) begin
        x = x + ((t <= 8) ? 15 : 14);
        set_exp(S_RACE, 2'd0, 1'b0, 11'(x), 11'd256, 2'd0);
        tick(4'd0, 1'b1, "decay");
      end
    end

    // Abort wins over a simultaneous tick and accelerate key
    set_exp(S_MENU, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    step(1'b1, 4'b1001, 1'b0, 1'b1, "abort");
    step(1'b0, 4'd0, 1'b0, 1'b0, "");

    // Finish: P1 to 260 at speed 4, then 42 ticks at 15 -> 890, then clamp
    to_race();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0001, 1'b0, 1'b0, "");
    set_exp(S_RACE, 2'd0, 1'b0, 11'd260, 11'd256, 2'd0);
    tick(4'd0, 1'b1, "p1_run");
    for (int i = 0; i < 11; i++) step(1'b0, 4'b0001, 1'b0, 1'b0, "");
    for (int k = 1; k <= 42; k++) begin
      set_exp(S_RACE, 2'd0, 1'b0, 11'(260 + 15 * k), 11'd256, 2'd0);
      tick(4'b0001, 1'b1, "p1_run");
    end
    set_exp(S_FIN, 2'd0, 1'b0, 11'd896, 11'd256, 2'd1);
    tick(4'd0, 1'b1, "finish_p1");
    tick(4'b0011, 1'b1, "finish_hold");
    step(1'b0, 4'b0001, 1'b0, 1'b1, "finish_hold");

    // Countdown abuse
    set_exp(S_CD, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    step(1'b0, 4'd0, 1'b1, 1'b1, "restart_from_finish");
    set_exp(S_FIN, 2'd3, 1'b0, 11'd256, 11'd256, 2'd1);
    step(1'b0, 4'b0010, 1'b0, 1'b1, "false_start_p2");
    set_exp(S_CD, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    step(1'b0, 4'd0, 1'b1, 1'b1, "restart");
    tick(4'd0, 1'b1, "cd_pre");
    tick(4'd0, 1'b1, "cd_pre");
    step(1'b0, 4'b0011, 1'b0, 1'b1, "both_keys");
    for (int t = 1; t <= 3; t++) tick(4'd0, 1'b1, "frame_restart");
    set_exp(S_CD, 2'd2, 1'b0, 11'd256, 11'd256, 2'd0);
    tick(4'd0, 1'b1, "frame_restart");
    set_exp(S_FIN, 2'd2, 1'b0, 11'd256, 11'd256, 2'd2);
    step(1'b0, 4'b0001, 1'b0, 1'b1, "false_start_p1");

    // Tie: both at speed 10; keys on every decay tick keep speed at 10
    to_race();
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0011, 1'b0, 1'b0, "");
    set_exp(S_RACE, 2'd0, 1'b0, 11'd260, 11'd260, 2'd0);
    tick(4'd0, 1'b1, "tie_run");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0011, 1'b0, 1'b0, "");
    for (int t = 2; t <= 64; t++) begin
      set_exp(S_RACE, 2'd0, 1'b0, 11'(260 + 10 * (t - 1)), 11'(260 + 10 * (t - 1)), 2'd0);
      tick(((t % 8) == 0) ? 4'b0011 : 4'b0000, 1'b1, "decay_key");
    end
    set_exp(S_FIN, 2'd0, 1'b0, 11'd896, 11'd896, 2'd3);
    tick(4'd0, 1'b1, "tie");

    // Asynchronous reset mid-race
    to_race();
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0011, 1'b0, 1'b0, "");
    set_exp(S_RACE, 2'd0, 1'b0, 11'd261, 11'd261, 2'd0);
    tick(4'd0, 1'b1, "pre_reset");
    @(posedge clk); #2; rst = 1'b1;
    set_exp(S_MENU, 2'd3, 1'b0, 11'd256, 11'd256, 2'd0);
    #1; push_exp(cyc, "async_reset");
    @(negedge clk); @(negedge clk); rst = 1'b0;
    step(1'b0, 4'd0, 1'b0, 1'b1, "post_reset");
    to_race();
    set_exp(S_RACE, 2'd0, 1'b0, 11'd256, 11'd256, 2'd0);
    tick(4'd0, 1'b1, "no_residual");

    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
